// File: rtl/ifft_dif_butterfly_pipe.sv
// Radix-2 DIF butterfly for the inverse path: X=a+b, Y=(a-b)*conj(w), optional /2 and saturation.
// Three registered stages under one global enable; a stalled output freezes the whole pipe.
module ifft_dif_butterfly_pipe #(
  parameter int WIDTH    = 12,
  parameter int FRACTION = 8,
  parameter int SCALE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic [WIDTH-1:0] w_re,
  input  logic [WIDTH-1:0] w_im,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_re,
  output logic [WIDTH-1:0] x_im,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im,
  output logic             out_last,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int SW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 2;
  localparam logic signed [PW-1:0] MAXV = $signed({{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] MINV = $signed({{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

  function automatic logic signed [PW-1:0] ext_s(input logic [SW-1:0] v);
    return $signed({{(PW-SW){v[SW-1]}}, v});
  endfunction

  function automatic logic signed [PW-1:0] ext_w(input logic [WIDTH-1:0] v);
    return $signed({{(PW-WIDTH){v[WIDTH-1]}}, v});
  endfunction

  // Returns {saturated_flag, clamped_value}.
  function automatic logic [WIDTH:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV) return {1'b1, MAXV[WIDTH-1:0]};
    else if (v < MINV) return {1'b1, MINV[WIDTH-1:0]};
    else return {1'b0, v[WIDTH-1:0]};
  endfunction

  logic adv;

  logic          v1_q, v1_d, last1_q, last1_d;
  logic [SW-1:0] s_re1_q, s_re1_d, s_im1_q, s_im1_d;
  logic [SW-1:0] d_re1_q, d_re1_d, d_im1_q, d_im1_d;
  logic [WIDTH-1:0] w_re1_q, w_re1_d, w_im1_q, w_im1_d;

  logic          v2_q, v2_d, last2_q, last2_d;
  logic [SW-1:0] s_re2_q, s_re2_d, s_im2_q, s_im2_d;
  logic signed [PW-1:0] pr2_q, pr2_d, pi2_q, pi2_d;

  logic          v3_q, v3_d, last3_q, last3_d, ovf3_q, ovf3_d, sticky_q, sticky_d;
  logic [WIDTH-1:0] x_re_q, x_re_d, x_im_q, x_im_d, y_re_q, y_re_d, y_im_q, y_im_d;

  logic signed [PW-1:0] xr_w, xi_w, yr_w, yi_w;
  logic [WIDTH:0] xr_s, xi_s, yr_s, yi_s;

  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    xr_w = ext_s(s_re2_q) >>> SCALE;
    xi_w = ext_s(s_im2_q) >>> SCALE;
    // Floor shift: the extra SCALE bit folds into one arithmetic shift.
    yr_w = pr2_q >>> (FRACTION + SCALE);
    yi_w = pi2_q >>> (FRACTION + SCALE);
    xr_s = sat(xr_w);
    xi_s = sat(xi_w);
    yr_s = sat(yr_w);
    yi_s = sat(yi_w);
  end

  always_comb begin
    v1_d = v1_q;       last1_d = last1_q;
    s_re1_d = s_re1_q; s_im1_d = s_im1_q;
    d_re1_d = d_re1_q; d_im1_d = d_im1_q;
    w_re1_d = w_re1_q; w_im1_d = w_im1_q;
    v2_d = v2_q;       last2_d = last2_q;
    s_re2_d = s_re2_q; s_im2_d = s_im2_q;
    pr2_d = pr2_q;     pi2_d = pi2_q;
    v3_d = v3_q;       last3_d = last3_q;   ovf3_d = ovf3_q;
    x_re_d = x_re_q;   x_im_d = x_im_q;
    y_re_d = y_re_q;   y_im_d = y_im_q;
    sticky_d = sticky_q;

    if (adv) begin
      v1_d    = in_valid;
      last1_d = in_last;
      s_re1_d = {a_re[WIDTH-1], a_re} + {b_re[WIDTH-1], b_re};
      s_im1_d = {a_im[WIDTH-1], a_im} + {b_im[WIDTH-1], b_im};
      d_re1_d = {a_re[WIDTH-1], a_re} - {b_re[WIDTH-1], b_re};
      d_im1_d = {a_im[WIDTH-1], a_im} - {b_im[WIDTH-1], b_im};
      w_re1_d = w_re;
      w_im1_d = w_im;

      v2_d    = v1_q;
      last2_d = last1_q;
      s_re2_d = s_re1_q;
      s_im2_d = s_im1_q;
      // Multiply by conj(w): (dr + j di)(wr - j wi).
      pr2_d = ext_s(d_re1_q) * ext_w(w_re1_q) + ext_s(d_im1_q) * ext_w(w_im1_q);
      pi2_d = ext_s(d_im1_q) * ext_w(w_re1_q) - ext_s(d_re1_q) * ext_w(w_im1_q);

      v3_d    = v2_q;
      last3_d = last2_q;
      x_re_d  = xr_s[WIDTH-1:0];
      x_im_d  = xi_s[WIDTH-1:0];
      y_re_d  = yr_s[WIDTH-1:0];
      y_im_d  = yi_s[WIDTH-1:0];
      ovf3_d  = xr_s[WIDTH] | xi_s[WIDTH] | yr_s[WIDTH] | yi_s[WIDTH];
    end

    if (ovf_clr) sticky_d = 1'b0;
    if (v3_q && out_ready && ovf3_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;   last1_q <= 1'b0;
      s_re1_q <= '0;  s_im1_q <= '0;  d_re1_q <= '0;  d_im1_q <= '0;
      w_re1_q <= '0;  w_im1_q <= '0;
      v2_q <= 1'b0;   last2_q <= 1'b0;
      s_re2_q <= '0;  s_im2_q <= '0;  pr2_q <= '0;    pi2_q <= '0;
      v3_q <= 1'b0;   last3_q <= 1'b0; ovf3_q <= 1'b0;
      x_re_q <= '0;   x_im_q <= '0;   y_re_q <= '0;   y_im_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      v1_q <= v1_d;       last1_q <= last1_d;
      s_re1_q <= s_re1_d; s_im1_q <= s_im1_d;
      d_re1_q <= d_re1_d; d_im1_q <= d_im1_d;
      w_re1_q <= w_re1_d; w_im1_q <= w_im1_d;
      v2_q <= v2_d;       last2_q <= last2_d;
      s_re2_q <= s_re2_d; s_im2_q <= s_im2_d;
      pr2_q <= pr2_d;     pi2_q <= pi2_d;
      v3_q <= v3_d;       last3_q <= last3_d;   ovf3_q <= ovf3_d;
      x_re_q <= x_re_d;   x_im_q <= x_im_d;
      y_re_q <= y_re_d;   y_im_q <= y_im_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = v3_q;
  assign out_last   = last3_q;
  assign ovf        = ovf3_q;
  assign ovf_sticky = sticky_q;
  assign x_re       = x_re_q;
  assign x_im       = x_im_q;
  assign y_re       = y_re_q;
  assign y_im       = y_im_q;

endmodule

// File: tb/tb_ifft_dif_butterfly_pipe.sv
// Bench for ifft_dif_butterfly_pipe: one instance per SCALE setting, shared stimulus,
// expected results from plain integer arithmetic on the butterfly equations.
module tb_ifft_dif_butterfly_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_last, out_ready, ovf_clr;
  logic [11:0] a_re, a_im, b_re, b_im, w_re, w_im;

  logic in_ready0, out_valid0, out_last0, ovf0, sticky0;
  logic in_ready1, out_valid1, out_last1, ovf1, sticky1;
  logic [11:0] x_re0, x_im0, y_re0, y_im0, x_re1, x_im1, y_re1, y_im1;

  ifft_dif_butterfly_pipe #(.WIDTH(12), .FRACTION(8), .SCALE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0),
    .out_last(out_last0), .ovf(ovf0), .ovf_sticky(sticky0), .ovf_clr(ovf_clr));

  ifft_dif_butterfly_pipe #(.WIDTH(12), .FRACTION(8), .SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1),
    .out_last(out_last1), .ovf(ovf1), .ovf_sticky(sticky1), .ovf_clr(ovf_clr));

  typedef struct {
    int xr; int xi; int yr; int yi; int last; int ovf;
  } exp_t;

  exp_t        qs[2][$];
  exp_t        pend[2];
  int          sexp[2];
  int          hold[2];
  logic [49:0] prev[2];
  int checks = 0;
  int errors = 0;
  int acc, seen0;

  function automatic exp_t model(int ar, int ai, int br, int bi, int wr, int wi, int lst, int sc);
    exp_t e;
    int r[4];
    int dr, di, o;
    dr = ar - br;
    di = ai - bi;
    r[0] = (ar + br) >>> sc;
    r[1] = (ai + bi) >>> sc;
    r[2] = (dr * wr + di * wi) >>> (8 + sc);
    r[3] = (di * wr - dr * wi) >>> (8 + sc);
    o = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] > 2047) begin r[i] = 2047; o = 1; end
      else if (r[i] < -2048) begin r[i] = -2048; o = 1; end
    end
    e.xr = r[0]; e.xi = r[1]; e.yr = r[2]; e.yi = r[3];
    e.last = lst; e.ovf = o;
    return e;
  endfunction

  function automatic int r12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic int rtw();
    case ($urandom_range(0, 3))
      0: return -2048;
      1: return 256;
      2: return 2047;
      default: return r12();
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(string tag, logic [49:0] obs, logic [49:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pair(int ar, int ai, int br, int bi, int wr, int wi, int lst);
    a_re = ar[11:0]; a_im = ai[11:0];
    b_re = br[11:0]; b_im = bi[11:0];
    w_re = wr[11:0]; w_im = wi[11:0];
    in_last  = lst[0];
    in_valid = 1'b1;
    pend[0] = model(ar, ai, br, bi, wr, wi, lst, 0);
    pend[1] = model(ar, ai, br, bi, wr, wi, lst, 1);
  endtask

  task automatic chk_dut(int id, logic ir, logic ov, logic [11:0] xr, logic [11:0] xi,
                         logic [11:0] yr, logic [11:0] yi, logic lst, logic ovo, logic stk);
    logic [49:0] cur;
    exp_t e;
    string p;
    p = (id == 0) ? "s0." : "s1.";
    chk({p, "ovf_sticky"}, int'(stk), sexp[id]);
    chk({p, "in_ready"}, int'(ir), (ov && !out_ready) ? 0 : 1);
    cur = {xr, xi, yr, yi, lst, ovo};
    if (hold[id] != 0) begin
      chk({p, "held_valid"}, int'(ov), 1);
      chkv({p, "held_data"}, cur, prev[id]);
    end
    if (ov && out_ready) begin
      chk({p, "out_expected"}, (qs[id].size() > 0) ? 1 : 0, 1);
      if (qs[id].size() > 0) begin
        e = qs[id].pop_front();
        chk({p, "x_re"}, int'($signed(xr)), e.xr);
        chk({p, "x_im"}, int'($signed(xi)), e.xi);
        chk({p, "y_re"}, int'($signed(yr)), e.yr);
        chk({p, "y_im"}, int'($signed(yi)), e.yi);
        chk({p, "out_last"}, int'(lst), e.last);
        chk({p, "ovf"}, int'(ovo), e.ovf);
        if (e.ovf != 0) sexp[id] = 1;
        else if (ovf_clr) sexp[id] = 0;
      end else if (ovf_clr) sexp[id] = 0;
    end else if (ovf_clr) sexp[id] = 0;
    hold[id] = (ov && !out_ready) ? 1 : 0;
    prev[id] = cur;
  endtask

  task automatic cycle();
    @(negedge clk);
    seen0 = int'(out_valid0);
    acc   = (in_valid && in_ready0) ? 1 : 0;
    if (in_valid && in_ready0) qs[0].push_back(pend[0]);
    if (in_valid && in_ready1) qs[1].push_back(pend[1]);
    chk_dut(0, in_ready0, out_valid0, x_re0, x_im0, y_re0, y_im0, out_last0, ovf0, sticky0);
    chk_dut(1, in_ready1, out_valid1, x_re1, x_im1, y_re1, y_im1, out_last1, ovf1, sticky1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_accept(string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (acc == 0 && n < 100);
    chk({tag, ".accepted"}, acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qs[0].delete();
    qs[1].delete();
    sexp = '{0, 0};
    hold = '{0, 0};
    @(negedge clk);
    chk("rst.out_valid0", int'(out_valid0), 0);
    chk("rst.out_valid1", int'(out_valid1), 0);
    chk("rst.ovf_sticky0", int'(sticky0), 0);
    chk("rst.ovf_sticky1", int'(sticky1), 0);
    chk("rst.x_re0", int'(x_re0), 0);
    chk("rst.out_last0", int'(out_last0), 0);
    chk("rst.ovf0", int'(ovf0), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, idx;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed vectors with hand-computed results for both scalings.
    set_pair(256, 0, 128, 0, 256, 0, 0);
    pend[0] = '{384, 0, 128, 0, 0, 0};
    pend[1] = '{192, 0, 64, 0, 0, 0};
    drive_accept("d1");
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (seen0 == 0 && lat < 10);
    chk("d1.latency", lat, 3);
    repeat (3) cycle();

    set_pair(150, 50, 50, 0, 0, 256, 0);
    pend[0] = '{200, 50, 50, -100, 0, 0};
    pend[1] = '{100, 25, 25, -50, 0, 0};
    drive_accept("d2");
    repeat (5) cycle();

    set_pair(2047, 0, 2047, 0, 256, 0, 0);
    pend[0] = '{2047, 0, 0, 0, 0, 1};
    pend[1] = '{2047, 0, 0, 0, 0, 0};
    drive_accept("d3");
    repeat (5) cycle();
    chk("d3.sticky_set0", int'(sticky0), 1);
    chk("d3.sticky_clear1", int'(sticky1), 0);

    set_pair(-2, 0, -1, 0, 256, 0, 1);
    pend[0] = '{-3, 0, -1, 0, 1, 0};
    pend[1] = '{-2, 0, -1, 0, 1, 0};
    drive_accept("d4");
    repeat (5) cycle();

    // Reset with three pairs in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      set_pair(r12(), r12(), r12(), r12(), rtw(), rtw(), 0);
      drive_accept("rf");
    end
    do_reset();
    repeat (6) cycle();

    // Ten-pair stream with a five-cycle downstream stall in the middle.
    idx = 0;
    for (int c = 0; c < 80 && (idx < 10 || qs[0].size() > 0 || qs[1].size() > 0); c++) begin
      out_ready = (c < 4 || c >= 9) ? 1'b1 : 1'b0;
      if (idx < 10 && !in_valid)
        set_pair(r12(), r12(), r12(), r12(), rtw(), rtw(), (idx == 9) ? 1 : 0);
      cycle();
      if (acc != 0) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    chk("stream.count", idx, 10);
    chk("stream.drain0", qs[0].size(), 0);
    chk("stream.drain1", qs[1].size(), 0);

    // Random traffic, random backpressure and sticky clears.
    for (int c = 0; c < 400; c++) begin
      if (!in_valid && $urandom_range(0, 3) != 0)
        set_pair(r12(), r12(), r12(), r12(), rtw(), rtw(), int'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      ovf_clr   = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      cycle();
      if (acc != 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("rand.drain0", qs[0].size(), 0);
    chk("rand.drain1", qs[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
